// File: rtl/bram_frame_reader_if.sv
// bram_frame_reader_if
//   Bundles the two buses of the frame reader: the read side of the block
//   memory (port A) and the valid/ready byte stream towards the consumer.
//   master : the reader (drives mem_en/mem_addr and the stream payload)
//   slave  : memory + consumer (drives mem_dout and m_ready)
// Signals:
//   mem_en    reader -> memory   read enable, one cycle per read
//   mem_addr  reader -> memory   read address
//   mem_dout  memory -> reader   read data, valid one cycle after mem_en
//   m_data    reader -> sink     stream byte
//   m_valid   reader -> sink     stream valid
//   m_ready   sink   -> reader   stream ready
//   m_last    reader -> sink     final beat of a drain
interface bram_frame_reader_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        output mem_en,
        output mem_addr,
        input  mem_dout,
        output m_data,
        output m_valid,
        input  m_ready,
        output m_last
    );

    modport slave (
        input  mem_en,
        input  mem_addr,
        output mem_dout,
        input  m_data,
        input  m_valid,
        output m_ready,
        input  m_last
    );
endinterface

// File: rtl/bram_frame_reader.sv
// bram_frame_reader
//   Drains len entries of a block memory (addresses 0..len-1) into a
//   valid/ready byte stream. The memory's one-cycle read latency is hidden
//   by a two-entry output FIFO, so the stream runs at one byte per clock
//   while m_ready stays high.
// Ports:
//   clk_i    clock shared with memory port A
//   rst_ni   asynchronous active-low reset
//   start_i  one-cycle request; len_i sampled with it (ignored unless idle)
//   len_i    entry count, clamped to DEPTH
//   busy_o   drain in progress
//   done_o   one-cycle pulse at the end of a drain
//   bus      memory read port + output stream (master modport)
// Build option:
//   BRAM_FRAME_READER_CHECKSUM_EN - append a mod-2^DATA_W sum of all data
//   bytes as one extra beat, which then carries m_last.
module bram_frame_reader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [ADDR_W:0]     len_i,
    output logic                busy_o,
    output logic                done_o,
    bram_frame_reader_if.master bus
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

    localparam logic [ADDR_W:0] MaxLen = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LenOne = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0]   len_clamped;
    logic              inflight_q;
    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] data_q [2];
    logic [1:0]        last_q;

    logic              mem_en;
    logic              final_rd;
    logic              start_acc;
    logic              pop;
    logic              room;
    logic              drained;
    logic [2:0]        level;
    logic              fifo_wr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;

`ifdef BRAM_FRAME_READER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              csum_sent_q, csum_sent_d;
    logic              csum_push;
`else
    logic              infl_last_q;
`endif

    assign pop         = (count_q != 2'd0) && bus.m_ready;
    assign len_clamped = (len_i > MaxLen) ? MaxLen : len_i;
    assign final_rd    = (rd_cnt_q + LenOne) == len_q;

    // Entries already committed to the FIFO: buffered plus the read in flight.
    // A pop this cycle frees one slot, so the read may go out in the same cycle.
    assign level = {1'b0, count_q} + {2'b00, inflight_q};
    assign room  = level < (3'd2 + {2'b00, pop});

`ifdef BRAM_FRAME_READER_CHECKSUM_EN
    // Checksum only goes in once the last data byte has landed in the FIFO.
    assign csum_push = (state_q == StDrain) && !csum_sent_q && !inflight_q && room;
    // Last entry leaves the FIFO this cycle (or it is already empty).
    assign drained   = csum_sent_q && !inflight_q &&
                       ((count_q == 2'd0) || ((count_q == 2'd1) && pop));
`else
    assign drained   = !inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop));
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rd_cnt_d  = rd_cnt_q;
        mem_en    = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    len_d     = len_clamped;
                    rd_cnt_d  = '0;
                    // A zero-length drain passes through StDrain (trivially empty) so
                    // that busy shows for one cycle before done.
                    state_d   = (len_clamped == '0) ? StDrain : StRead;
                end
            end
            StRead: begin
                if (room) begin
                    mem_en   = 1'b1;
                    rd_cnt_d = rd_cnt_q + LenOne;
                    if (final_rd) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (drained) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
`ifdef BRAM_FRAME_READER_CHECKSUM_EN
        fifo_wr     = inflight_q | csum_push;
        wr_data     = inflight_q ? bus.mem_dout : sum_q;
        wr_last     = !inflight_q;
        sum_d       = sum_q;
        csum_sent_d = csum_sent_q;
        if (start_acc) begin
            sum_d       = '0;
            csum_sent_d = 1'b0;
        end else begin
            if (inflight_q) begin
                sum_d = sum_q + bus.mem_dout;
            end
            if (csum_push) begin
                csum_sent_d = 1'b1;
            end
        end
`else
        fifo_wr = inflight_q;
        wr_data = bus.mem_dout;
        wr_last = infl_last_q;
`endif
        count_d = count_q;
        if (fifo_wr && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!fifo_wr && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            inflight_q  <= 1'b0;
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            data_q[0]   <= '0;
            data_q[1]   <= '0;
            last_q      <= 2'b00;
`ifdef BRAM_FRAME_READER_CHECKSUM_EN
            sum_q       <= '0;
            csum_sent_q <= 1'b0;
`else
            infl_last_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            inflight_q <= mem_en;
            count_q    <= count_d;
`ifdef BRAM_FRAME_READER_CHECKSUM_EN
            sum_q       <= sum_d;
            csum_sent_q <= csum_sent_d;
`else
            infl_last_q <= mem_en && final_rd;
`endif
            if (fifo_wr) begin
                data_q[wr_ptr_q] <= wr_data;
                last_q[wr_ptr_q] <= wr_last;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign bus.mem_en   = mem_en;
    assign bus.mem_addr = rd_cnt_q[ADDR_W-1:0];
    assign bus.m_valid  = count_q != 2'd0;
    assign bus.m_data   = data_q[rd_ptr_q];
    // Stale last flags stay in the slots after a pop; gate with valid.
    assign bus.m_last   = (count_q != 2'd0) && last_q[rd_ptr_q];

    assign busy_o = (state_q == StRead) || (state_q == StDrain);
    assign done_o = state_q == StFin;

endmodule

// File: tb/tb_bram_frame_reader.sv
// tb_bram_frame_reader
//   Scoreboard bench for bram_frame_reader. Each drain request pushes the
//   expected beat sequence (computed from the memory image and the length
//   rules) into a queue; an independent monitor pops and compares every
//   accepted beat, and also watches read addresses, buffer room, stream
//   stability while stalled and done pulses.
`timescale 1ns/1ps
module tb_bram_frame_reader;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
`ifdef BRAM_FRAME_READER_CHECKSUM_EN
    localparam bit Csum = 1'b1;
`else
    localparam bit Csum = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         cyc;   // expected cycle after the start edge, 0 = unchecked
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   len;
    logic          busy;
    logic          done;

    logic [7:0]    mem [DEPTH];
    beat_t         exp_q [$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int base_cyc = 0;
    int beats_seen = 0;
    int reads_seen = 0;
    int done_cnt = 0;

    bram_frame_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bram_frame_reader #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .start_i(start),
        .len_i  (len),
        .busy_o (busy),
        .done_o (done),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Block memory port A: registered read.
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_dout <= mem[bus.mem_addr];
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_mem_en"},   int'(bus.mem_en),   0);
        check({tag, "_mem_addr"}, int'(bus.mem_addr), 0);
        check({tag, "_m_data"},   int'(bus.m_data),   0);
        check({tag, "_m_valid"},  int'(bus.m_valid),  0);
        check({tag, "_m_last"},   int'(bus.m_last),   0);
        check({tag, "_busy"},     int'(busy),         0);
        check({tag, "_done"},     int'(done),         0);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        beat_t      e;
        bit         pop;
        bit         busy_prev;
        bit         stall_q;
        logic [7:0] hold_data;
        logic       hold_last;
        int         exp_addr;
        int         outstanding;
        busy_prev   = 1'b0;
        stall_q     = 1'b0;
        hold_data   = 8'h00;
        hold_last   = 1'b0;
        exp_addr    = 0;
        outstanding = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                stall_q     = 1'b0;
                busy_prev   = 1'b0;
                outstanding = 0;
            end else begin
                pop = bus.m_valid && bus.m_ready;
                if (busy && !busy_prev) begin
                    exp_addr    = 0;
                    outstanding = 0;
                end
                busy_prev = busy;
                if (done) done_cnt++;
                if (stall_q) begin
                    check("stall_valid", int'(bus.m_valid), 1);
                    check("stall_data",  int'(bus.m_data),  int'(hold_data));
                    check("stall_last",  int'(bus.m_last),  int'(hold_last));
                end
                if (bus.mem_en) begin
                    check("rd_addr", int'(bus.mem_addr), exp_addr);
                    check("rd_room", int'((outstanding - int'(pop)) < 2), 1);
                    exp_addr++;
                    reads_seen++;
                end
                if (pop) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat got=%0h t=%0t", bus.m_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", int'(bus.m_data), int'(e.data));
                        check("beat_last", int'(bus.m_last), int'(e.last));
                        if (e.cyc != 0) check("beat_cycle", cyc - base_cyc + 1, e.cyc);
                    end
                    beats_seen++;
                end
                outstanding = outstanding + int'(bus.mem_en) - int'(pop);
                stall_q   = bus.m_valid && !bus.m_ready;
                hold_data = bus.m_data;
                hold_last = bus.m_last;
            end
        end
    end

    // One drain: l = requested length, rnd = random m_ready, abort_after =
    // beats before an asynchronous reset (0 = none), second_at = cycle of an
    // extra start pulse while busy (0 = none).
    task automatic run_drain(input int l, input bit rnd, input int abort_after,
                             input int second_at);
        int         n;
        int         exp_done;
        int         beats_base;
        int         reads_base;
        int         done_base;
        bit         got;
        logic [7:0] sum;
        beat_t      b;
        n   = (l > DEPTH) ? DEPTH : l;
        sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            b.data = mem[i];
            b.last = !Csum && (i == n - 1);
            b.cyc  = rnd ? 0 : 3 + i;
            exp_q.push_back(b);
            sum = sum + mem[i];
        end
        if (Csum) begin
            b.data = sum;
            b.last = 1'b1;
            b.cyc  = rnd ? 0 : ((n == 0) ? 2 : n + 3);
            exp_q.push_back(b);
        end
        exp_done   = Csum ? ((n == 0) ? 3 : n + 4) : ((n == 0) ? 2 : n + 3);
        beats_base = beats_seen;
        reads_base = reads_seen;
        done_base  = done_cnt;
        got        = 1'b0;

        @(negedge clk);
        start       = 1'b1;
        len         = 5'(l);
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        base_cyc = cyc;
        for (int k = 1; k <= 400; k++) begin
            if (abort_after > 0 && (beats_seen - beats_base) >= abort_after) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_zero("abort");
                repeat (2) @(negedge clk);
                check("abort_no_done", done_cnt - done_base, 0);
                @(posedge clk);
                #2;
                rst_n = 1'b1;
                start = 1'b0;
                return;
            end
            start       = (k == second_at);
            bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (k == 1) check("busy_c1", int'(busy), 1);
            if (done) begin
                got = 1'b1;
                if (!rnd) check("done_cycle", k, exp_done);
                check("busy_at_done", int'(busy), 0);
                check("beats_left", exp_q.size(), 0);
                check("read_count", reads_seen - reads_base, n);
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL done_timeout len=%0d t=%0t", l, $time);
        end
        repeat (3) @(negedge clk);
        check("one_done",   done_cnt - done_base, 1);
        check("idle_valid", int'(bus.m_valid), 0);
        check("idle_busy",  int'(busy), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        len         = '0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h10 + i);
        #12;
        check_zero("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset");

        run_drain(16, 1'b0, 0, 0);   // full-ready drain
        run_drain(5,  1'b1, 0, 0);   // random backpressure
        run_drain(0,  1'b0, 0, 0);   // zero length
        run_drain(20, 1'b0, 0, 0);   // clamped to DEPTH
        run_drain(6,  1'b0, 0, 4);   // start while busy
        run_drain(10, 1'b0, 3, 0);   // reset after three beats
        run_drain(5,  1'b0, 0, 0);   // restarts from address 0

        mem[0] = 8'hFF;
        mem[1] = 8'h01;
        mem[2] = 8'h80;
        mem[3] = 8'h80;
        run_drain(4, 1'b0, 0, 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
            run_drain(int'($urandom_range(0, 20)), 1'b1, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
